// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B3 signal bundle between the requesting masters and the shared wb_io slave port.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int num_masters = 3
);
  logic [32*num_masters-1:0] wbm_adr_i;
  logic [32*num_masters-1:0] wbm_dat_i;
  logic [32*num_masters-1:0] wbm_dat_o;
  logic [4*num_masters-1:0]  wbm_sel_i;
  logic [num_masters-1:0]    wbm_we_i;
  logic [num_masters-1:0]    wbm_cyc_i;
  logic [num_masters-1:0]    wbm_stb_i;
  logic [3*num_masters-1:0]  wbm_cti_i;
  logic [2*num_masters-1:0]  wbm_bte_i;
  logic [num_masters-1:0]    wbm_ack_o;
  logic [num_masters-1:0]    wbm_err_o;
  logic [num_masters-1:0]    wbm_rty_o;

  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic        wbs_rty_i;

  modport master (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
  );

  modport slave (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the wb_io port: one owner per cyc,
// responses routed only to the owner, and a watchdog that aborts hung accesses with err.
module wb_rr_arbiter #(
  parameter int num_masters = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_rr_arbiter_if.master        bus,
  output logic [num_masters-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int OW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   owner_d;
  logic            pickValid;
  logic            ownCyc;
  logic            ownStb;
  logic            slvResp;

  // Search upward from last+1; iterating from the far end lets the nearest requester win.
  always_comb begin
    int idx;
    idx       = 0;
    owner_d   = last_q;
    pickValid = 1'b0;
    for (int i = num_masters; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= num_masters) idx = idx - num_masters;
      if (bus.wbm_cyc_i[idx]) begin
        owner_d   = OW'(idx);
        pickValid = 1'b1;
      end
    end
  end

  assign ownCyc  = bus.wbm_cyc_i[owner_q];
  assign ownStb  = bus.wbm_stb_i[owner_q];
  assign slvResp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(num_masters - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pickValid) begin
            owner_q <= owner_d;
            last_q  <= owner_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!ownCyc) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (slvResp || !ownStb || (TIMEOUT == 0)) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ABORT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ABORT: begin
          cnt_q   <= '0;
          state_q <= ownCyc ? BUSY : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    grant_o = '0;
    if (state_q != IDLE) grant_o[owner_q] = 1'b1;
  end

  assign timeout_o = (state_q == ABORT);

  // Slave responses pass straight through to the owner; an abort fabricates err instead.
  always_comb begin
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    if (state_q == BUSY) begin
      bus.wbm_ack_o[owner_q] = bus.wbs_ack_i;
      bus.wbm_err_o[owner_q] = bus.wbs_err_i;
      bus.wbm_rty_o[owner_q] = bus.wbs_rty_i;
    end else if (state_q == ABORT) begin
      bus.wbm_err_o[owner_q] = 1'b1;
    end
  end

  assign bus.wbm_dat_o = {num_masters{bus.wbs_dat_i}};

  assign bus.wbs_adr_o = bus.wbm_adr_i[32*owner_q +: 32];
  assign bus.wbs_dat_o = bus.wbm_dat_i[32*owner_q +: 32];
  assign bus.wbs_sel_o = bus.wbm_sel_i[4*owner_q +: 4];
  assign bus.wbs_cti_o = bus.wbm_cti_i[3*owner_q +: 3];
  assign bus.wbs_bte_o = bus.wbm_bte_i[2*owner_q +: 2];
  assign bus.wbs_we_o  = bus.wbm_we_i[owner_q];
  assign bus.wbs_cyc_o = (state_q == BUSY) && ownCyc;
  assign bus.wbs_stb_o = (state_q == BUSY) && ownStb;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: response-routing vector table, round-robin
// ordering scoreboard, burst hold, watchdog abort/near-miss and mid-burst reset.
module tb_wb_rr_arbiter;
  localparam int NM  = 3;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] grant;
  logic          timeoutPulse;
  int            assertCount = 0;
  int            failCount   = 0;

  wb_rr_arbiter_if #(.num_masters(NM)) bus ();

  wb_rr_arbiter #(.num_masters(NM), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .grant_o  (grant),
    .timeout_o(timeoutPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stb;
    logic          we;
    logic [31:0]   adr;
    logic          ack;
    logic          err;
    logic          rty;
    logic [31:0]   sdat;
    logic          expStb;
    logic [NM-1:0] expAck;
    logic [NM-1:0] expErr;
    logic [NM-1:0] expRty;
  } vec_t;

  vec_t vecs[8];
  vec_t expQ[$];
  int   expGrantQ[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setMaster(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [2:0] cti);
    bus.wbm_cyc_i[k]          = cyc;
    bus.wbm_stb_i[k]          = stb;
    bus.wbm_we_i[k]           = we;
    bus.wbm_adr_i[32*k +: 32] = adr;
    bus.wbm_dat_i[32*k +: 32] = adr ^ 32'h5A5A_0000;
    bus.wbm_sel_i[4*k +: 4]   = 4'hF;
    bus.wbm_cti_i[3*k +: 3]   = cti;
    bus.wbm_bte_i[2*k +: 2]   = 2'b00;
  endtask

  task automatic setSlave(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    bus.wbs_ack_i = ack;
    bus.wbs_err_i = err;
    bus.wbs_rty_i = rty;
    bus.wbs_dat_i = dat;
  endtask

  // Bounded wait for a specific grant; an expired budget shows up as a failed comparison.
  task automatic waitGrant(input logic [NM-1:0] want, input string name);
    int n;
    n = 0;
    while (grant !== want && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(grant), 64'(want));
  endtask

  task automatic applyStimulus(input vec_t v);
    setMaster(2, 1'b1, v.stb, v.we, v.adr, 3'b000);
    setSlave(v.ack, v.err, v.rty, v.sdat);
    expQ.push_back(v);
  endtask

  task automatic checkVector(input int i);
    vec_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL vecQueue[%0d]: got empty queue, expected an entry", i);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("vecCyc[%0d]", i), 64'(bus.wbs_cyc_o), 64'(1'b1));
      checkOutput($sformatf("vecStb[%0d]", i), 64'(bus.wbs_stb_o), 64'(e.expStb));
      checkOutput($sformatf("vecAdr[%0d]", i), 64'(bus.wbs_adr_o), 64'(e.adr));
      checkOutput($sformatf("vecWe[%0d]", i),  64'(bus.wbs_we_o),  64'(e.we));
      checkOutput($sformatf("vecAck[%0d]", i), 64'(bus.wbm_ack_o), 64'(e.expAck));
      checkOutput($sformatf("vecErr[%0d]", i), 64'(bus.wbm_err_o), 64'(e.expErr));
      checkOutput($sformatf("vecRty[%0d]", i), 64'(bus.wbm_rty_o), 64'(e.expRty));
      checkOutput($sformatf("vecDat0[%0d]", i), 64'(bus.wbm_dat_o[31:0]), 64'(e.sdat));
    end
  endtask

  // Round-robin monitor: pops the expected owner on every new grant and checks the bus gap.
  logic          monOn = 1'b0;
  logic [NM-1:0] prevGrant = '0;
  int            gapCycles = 0;
  int            ownerships = 0;

  always @(negedge clk) begin
    int exp;
    if (monOn) begin
      if (grant != '0 && prevGrant == '0) begin
        if (ownerships > 0) checkOutput("rrGap", 64'(gapCycles), 64'(1));
        ownerships++;
        gapCycles = 0;
        if (expGrantQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL rrUnexpectedGrant: got 0x%0h, expected no further grant", grant);
        end else begin
          exp = expGrantQ.pop_front();
          checkOutput("rrOrder", 64'(grant), 64'(3'b001 << exp));
        end
      end else if (grant == '0) begin
        gapCycles++;
      end
    end else begin
      ownerships = 0;
      gapCycles  = 0;
    end
    prevGrant = grant;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got no finish, expected test end");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int earlyErr;
    int owner;
    int budget;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h1111_0001, 1'b1, 3'b100, 3'b000, 3'b000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b0, 32'h1111_0002, 1'b1, 3'b000, 3'b100, 3'b000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h1111_0003, 1'b1, 3'b000, 3'b000, 3'b100};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_010C, 1'b0, 1'b0, 1'b0, 32'h1111_0004, 1'b0, 3'b000, 3'b000, 3'b000};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0110, 1'b0, 1'b0, 1'b0, 32'h1111_0005, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0110, 1'b1, 1'b0, 1'b0, 32'h1111_0006, 1'b1, 3'b100, 3'b000, 3'b000};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0114, 1'b1, 1'b1, 1'b0, 32'h1111_0007, 1'b1, 3'b100, 3'b100, 3'b000};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0118, 1'b1, 1'b0, 1'b0, 32'h1111_0008, 1'b0, 3'b100, 3'b000, 3'b000};

    rst = 1'b1;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_sel_i = '0;
    bus.wbm_we_i  = '0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0;
    bus.wbm_bte_i = '0;
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset values
    tick();
    tick();
    checkOutput("rstGrant",   64'(grant),         64'(0));
    checkOutput("rstTimeout", 64'(timeoutPulse),  64'(0));
    checkOutput("rstCyc",     64'(bus.wbs_cyc_o), 64'(0));
    checkOutput("rstStb",     64'(bus.wbs_stb_o), 64'(0));
    checkOutput("rstAck",     64'(bus.wbm_ack_o), 64'(0));
    checkOutput("rstErr",     64'(bus.wbm_err_o), 64'(0));
    checkOutput("rstRty",     64'(bus.wbm_rty_o), 64'(0));
    rst = 1'b0;

    // Master 1 alone reads 0x00001040, slave acks two cycles after stb
    tick();
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_1040, 3'b000);
    settle();
    checkOutput("t1GrantIdle", 64'(grant), 64'(0));
    tick();
    checkOutput("t1Grant",   64'(grant),         64'(3'b010));
    checkOutput("t1Cyc",     64'(bus.wbs_cyc_o), 64'(1));
    checkOutput("t1Adr",     64'(bus.wbs_adr_o), 64'(32'h0000_1040));
    tick();
    checkOutput("t1NoAckYet", 64'(bus.wbm_ack_o), 64'(0));
    tick();
    setSlave(1'b1, 1'b0, 1'b0, 32'hCAFE_1234);
    settle();
    checkOutput("t1Ack", 64'(bus.wbm_ack_o), 64'(3'b010));
    checkOutput("t1Dat", 64'(bus.wbm_dat_o[63:32]), 64'(32'hCAFE_1234));
    tick();
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    checkOutput("t1CycDrop", 64'(bus.wbs_cyc_o), 64'(0));
    tick();
    checkOutput("t1Idle", 64'(grant), 64'(0));

    // Vector table: master 2 owns the bus while masters 0 and 1 keep requesting
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0000, 3'b000);
    setMaster(1, 1'b1, 1'b1, 1'b1, 32'hBBBB_0000, 3'b000);
    setMaster(2, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    checkOutput("vecOwner", 64'(grant), 64'(3'b100));
    for (int i = 0; i < 8; i++) begin
      tick();
      applyStimulus(vecs[i]);
      settle();
      checkVector(i);
    end
    tick();
    setMaster(2, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("vecRelCyc", 64'(bus.wbs_cyc_o), 64'(0));
    tick();
    checkOutput("vecRelIdle", 64'(grant), 64'(0));
    tick();
    checkOutput("vecNextOwner", 64'(grant), 64'(3'b001));

    // Master 0 runs a 4-beat incrementing burst while master 2 waits
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    setMaster(2, 1'b1, 1'b0, 1'b0, 32'h0000_9000, 3'b000);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_3000 + 32'(4*b), (b == 3) ? 3'b111 : 3'b010);
      setSlave(1'b1, 1'b0, 1'b0, 32'hB0B0_0000 + 32'(b));
      settle();
      checkOutput($sformatf("burstGrant[%0d]", b), 64'(grant),         64'(3'b001));
      checkOutput($sformatf("burstAck[%0d]", b),   64'(bus.wbm_ack_o), 64'(3'b001));
    end
    tick();
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("burstRelCyc", 64'(bus.wbs_cyc_o), 64'(0));
    tick();
    checkOutput("burstGap", 64'(grant), 64'(0));
    tick();
    checkOutput("burstNextOwner", 64'(grant), 64'(3'b100));
    checkOutput("burstNextAdr",   64'(bus.wbs_adr_o), 64'(32'h0000_9000));
    tick();
    setMaster(2, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // Round robin: three masters contend continuously, one access per ownership
    monOn = 1'b1;
    for (int n = 0; n < 6; n++) expGrantQ.push_back(n % 3);
    for (int k = 0; k < 3; k++) setMaster(k, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 3'b000);
    for (int n = 0; n < 6; n++) begin
      budget = 0;
      while (grant == '0 && budget < 10) begin
        tick();
        budget++;
      end
      if (grant == '0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL rrGrantWait: got 0x0, expected a grant within 10 cycles");
        break;
      end
      owner = (grant == 3'b001) ? 0 : (grant == 3'b010) ? 1 : 2;
      setMaster(owner, 1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(4*n), 3'b000);
      setSlave(1'b1, 1'b0, 1'b0, 32'h1111_0000 + 32'(n));
      tick();
      setSlave(1'b0, 1'b0, 1'b0, 32'h0);
      if (n == 5) begin
        for (int k = 0; k < 3; k++) setMaster(k, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      end else begin
        setMaster(owner, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
        setMaster(owner, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 3'b000);
      end
    end
    tick();
    tick();
    tick();
    monOn = 1'b0;
    checkOutput("rrQueueEmpty", 64'(expGrantQ.size()), 64'(0));

    // Watchdog: master 2 strobes 0x0000F000 and the slave never answers
    setMaster(2, 1'b1, 1'b0, 1'b0, 32'h0000_F000, 3'b000);
    waitGrant(3'b100, "toGrant");
    tick();
    setMaster(2, 1'b1, 1'b1, 1'b0, 32'h0000_F000, 3'b000);
    settle();
    checkOutput("toStbRise", 64'(bus.wbs_stb_o), 64'(1));
    earlyErr = 0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (bus.wbm_err_o != '0 || timeoutPulse) earlyErr++;
    end
    checkOutput("toNoEarlyErr", 64'(earlyErr), 64'(0));
    tick();
    checkOutput("toErr",     64'(bus.wbm_err_o), 64'(3'b100));
    checkOutput("toPulse",   64'(timeoutPulse),  64'(1));
    checkOutput("toCycLow",  64'(bus.wbs_cyc_o), 64'(0));
    checkOutput("toOwnKept", 64'(grant),         64'(3'b100));
    tick();
    setMaster(2, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    checkOutput("toPulseEnd", 64'(timeoutPulse),  64'(0));
    checkOutput("toErrEnd",   64'(bus.wbm_err_o), 64'(0));
    tick();
    checkOutput("toRelease", 64'(grant), 64'(0));

    // Watchdog near-miss: master 0 is acked in the last cycle before the abort
    setMaster(0, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 3'b000);
    waitGrant(3'b001, "nmGrant");
    tick();
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 3'b000);
    earlyErr = 0;
    for (int i = 1; i < TMO - 1; i++) begin
      tick();
      if (bus.wbm_err_o != '0 || timeoutPulse) earlyErr++;
    end
    tick();
    setSlave(1'b1, 1'b0, 1'b0, 32'h7777_0007);
    settle();
    checkOutput("nmNoEarlyErr", 64'(earlyErr),      64'(0));
    checkOutput("nmAck",        64'(bus.wbm_ack_o), 64'(3'b001));
    checkOutput("nmErr",        64'(bus.wbm_err_o), 64'(0));
    tick();
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    checkOutput("nmNoTimeout", 64'(timeoutPulse),  64'(0));
    checkOutput("nmNoErr",     64'(bus.wbm_err_o), 64'(0));
    tick();

    // Reset in the middle of a master 1 burst, then a three-way tie
    setMaster(1, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 3'b000);
    waitGrant(3'b010, "rstBurstGrant");
    tick();
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 3'b010);
    setSlave(1'b1, 1'b0, 1'b0, 32'h5555_0000);
    settle();
    checkOutput("rstBeatAck", 64'(bus.wbm_ack_o), 64'(3'b010));
    tick();
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_5004, 3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setMaster(0, 1'b1, 1'b0, 1'b0, 32'h0000_6000, 3'b000);
    setMaster(2, 1'b1, 1'b0, 1'b0, 32'h0000_6200, 3'b000);
    settle();
    checkOutput("rstMidCyc",   64'(bus.wbs_cyc_o), 64'(0));
    checkOutput("rstMidGrant", 64'(grant),         64'(0));
    checkOutput("rstMidAck",   64'(bus.wbm_ack_o), 64'(0));
    tick();
    setSlave(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rstTieWinner", 64'(grant), 64'(3'b001));
    for (int k = 0; k < 3; k++) setMaster(k, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
